// File: rtl/phase_readout_pkg.sv
// phase_readout_pkg: shared constants and types for the phase-counter readout sequencer.
//   PHASE_ADDR_BASE : byte address of phase counter 0 in the counter array
//   WORD_STRIDE     : byte distance between consecutive counter words
//   state_e         : sequencer state encoding (2 bits)
package phase_readout_pkg;

    localparam logic [31:0] PHASE_ADDR_BASE = 32'h4000_0000;
    localparam logic [31:0] WORD_STRIDE     = 32'd4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StSend = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/phase_readout.sv
// phase_readout: walks N phase counters through their word-addressed read port, streams each
// 32-bit count over valid/ready and latches a thresholded N-bit spin vector per sweep.
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   start           : sweep request, honoured only in IDLE
//   counter_cutoff  : unsigned threshold, held stable during a sweep
//   rd_addr / phase : registered read address and the combinational counter word it selects
//   out_valid/ready/data/last : word stream, out_last marks counter N-1
//   busy            : high outside IDLE
//   done            : one-cycle pulse after the final handshake
//   spins           : spin vector of the last completed sweep
module phase_readout
    import phase_readout_pkg::*;
#(
    parameter int unsigned N         = 3,
    parameter logic [31:0] ADDR_BASE = PHASE_ADDR_BASE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   counter_cutoff,
    output logic [31:0]   rd_addr,
    input  logic [31:0]   phase,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  spins
);

    localparam logic [31:0] LastIdx = 32'(N - 1);

    state_e         state_q, state_d;
    logic [31:0]    idx_q, idx_d;
    logic [31:0]    rd_addr_q, rd_addr_d;
    logic [31:0]    out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           done_q, done_d;
    logic [N-1:0]   spins_q, spins_d;
    logic [N-1:0]   shadow_q, shadow_d;

    logic           last_word;
    logic           handshake;

    assign last_word = (idx_q == LastIdx);
    assign handshake = out_valid_q && out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StAddr;
            StAddr: state_d = StSend;
            StSend: if (handshake) state_d = last_word ? StDone : StAddr;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: every stream output is registered, so out_ready never reaches
    // out_valid or out_data combinationally.
    always_comb begin
        idx_d       = idx_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = done_q;
        spins_d     = spins_q;
        shadow_d    = shadow_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d     = '0;
                    rd_addr_d = ADDR_BASE;
                end
            end
            StAddr: begin
                out_data_d  = phase;
                out_valid_d = 1'b1;
                out_last_d  = last_word;
                for (int unsigned i = 0; i < N; i++) begin
                    if (idx_q == 32'(i)) shadow_d[i] = (phase >= counter_cutoff);
                end
            end
            StSend: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    if (last_word) begin
                        out_last_d = 1'b0;
                        spins_d    = shadow_q;
                        done_d     = 1'b1;
                    end else begin
                        idx_d     = idx_q + 32'd1;
                        rd_addr_d = rd_addr_q + WORD_STRIDE;
                    end
                end
            end
            StDone: done_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            rd_addr_q   <= ADDR_BASE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            spins_q     <= '0;
            shadow_q    <= '0;
        end else begin
            idx_q       <= idx_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            spins_q     <= spins_d;
            shadow_q    <= shadow_d;
        end
    end

    // Output logic.
    always_comb begin
        busy      = (state_q != StIdle);
        rd_addr   = rd_addr_q;
        out_data  = out_data_q;
        out_valid = out_valid_q;
        out_last  = out_last_q;
        done      = done_q;
        spins     = spins_q;
    end

endmodule

// File: tb/tb_phase_readout.sv
module tb_phase_readout;
    import phase_readout_pkg::*;

    localparam logic [31:0] BASE = PHASE_ADDR_BASE;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // N=3 instance
    logic        start = 1'b0;
    logic [31:0] cutoff = '0;
    logic [31:0] rd_addr, phase, out_data;
    logic        out_valid, out_last, busy, done;
    logic        out_ready = 1'b1;
    logic [2:0]  spins;
    logic [31:0] mem [3];
    logic [31:0] widx;

    // N=1 instance
    logic        start1 = 1'b0;
    logic [31:0] cutoff1 = '0;
    logic [31:0] rd_addr1, phase1, out_data1;
    logic        out_valid1, out_last1, busy1, done1;
    logic        out_ready1 = 1'b1;
    logic [0:0]  spins1;
    logic [31:0] mem1 = '0;

    word_t       exp_q[$];
    logic [2:0]  spins_q[$];
    word_t       exp1_q[$];
    logic        spins1_q[$];
    word_t       mon_w, mon_w1;

    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          edges;

    phase_readout #(.N(3)) dut (
        .clk(clk), .rst(rst), .start(start), .counter_cutoff(cutoff), .rd_addr(rd_addr),
        .phase(phase), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .spins(spins)
    );

    phase_readout #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .counter_cutoff(cutoff1), .rd_addr(rd_addr1),
        .phase(phase1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1), .done(done1), .spins(spins1)
    );

    always #5 clk = ~clk;

    // Counter array models: word selected combinationally by the address.
    always_comb begin
        widx  = (rd_addr - BASE) >> 2;
        phase = (widx < 32'd3) ? mem[widx[1:0]] : 32'hDEAD_BEEF;
    end
    assign phase1 = (rd_addr1 == BASE) ? mem1 : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare on every handshake and every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("n3 unexpected word", out_data, 32'hFFFF_FFFF);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("n3 rd_addr", rd_addr, mon_w.addr);
                    check("n3 out_data", out_data, mon_w.data);
                    check("n3 out_last", {31'd0, out_last}, {31'd0, mon_w.last});
                end
            end
            if (done) begin
                done_cnt++;
                if (spins_q.size() == 0) check("n3 unexpected done", {29'd0, spins}, 32'hFFFF_FFFF);
                else check("n3 spins", {29'd0, spins}, {29'd0, spins_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid1 && out_ready1) begin
                if (exp1_q.size() == 0) begin
                    check("n1 unexpected word", out_data1, 32'hFFFF_FFFF);
                end else begin
                    mon_w1 = exp1_q.pop_front();
                    check("n1 rd_addr", rd_addr1, mon_w1.addr);
                    check("n1 out_data", out_data1, mon_w1.data);
                    check("n1 out_last", {31'd0, out_last1}, {31'd0, mon_w1.last});
                end
            end
            if (done1) begin
                if (spins1_q.size() == 0) check("n1 unexpected done", {31'd0, spins1}, 32'hFFFF);
                else check("n1 spins", {31'd0, spins1}, {31'd0, spins1_q.pop_front()});
            end
        end
    end

    // Pulse start; returns 1 time unit after the sampling edge E0.
    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int k_out);
        k_out = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                k_out = k;
                return;
            end
        end
        check("n3 done timeout", 32'd0, 32'd1);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] cut, input logic [2:0] sp);
        mem[0] = a; mem[1] = b; mem[2] = c; cutoff = cut;
        exp_q.push_back('{addr: BASE,          data: a, last: 1'b0});
        exp_q.push_back('{addr: BASE + 32'd4,  data: b, last: 1'b0});
        exp_q.push_back('{addr: BASE + 32'd8,  data: c, last: 1'b1});
        spins_q.push_back(sp);
    endtask

    task automatic sweep(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] cut, input logic [2:0] sp, input string name);
        int k;
        load(a, b, c, cut, sp);
        start_pulse();
        wait_done(k);
        check({name, " done latency"}, 32'(k), 32'd6);
        exp_done++;
        @(posedge clk); #1;
        check({name, " done width"}, {31'd0, done}, 32'd0);
        check({name, " spins held"}, {29'd0, spins}, {29'd0, sp});
    endtask

    task automatic sweep1(input logic [31:0] v, input logic [31:0] cut, input logic sp);
        int k;
        mem1 = v; cutoff1 = cut;
        exp1_q.push_back('{addr: BASE, data: v, last: 1'b1});
        spins1_q.push_back(sp);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        k = -1;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            if (done1) begin
                k = j;
                break;
            end
        end
        check("n1 done latency", 32'(k), 32'd2);
        @(posedge clk); #1;
        check("n1 busy after", {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        mem[0] = '0; mem[1] = '0; mem[2] = '0;
        #1 rst = 1'b1;
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset spins", {29'd0, spins}, 32'd0);
        check("reset rd_addr", rd_addr, BASE);
        check("reset out_data", out_data, 32'd0);
        check("reset out_last", {31'd0, out_last}, 32'd0);
        #10 rst = 1'b0;

        // Basic sweep with explicit first-word timing.
        load(32'd10, 32'd200, 32'd300, 32'd100, 3'b110);
        start_pulse();
        check("basic busy after E0", {31'd0, busy}, 32'd1);
        check("basic rd_addr after E0", rd_addr, BASE);
        check("basic valid after E0", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("basic valid after E1", {31'd0, out_valid}, 32'd1);
        check("basic data after E1", out_data, 32'd10);
        wait_done(edges);
        check("basic done latency", 32'(edges + 1), 32'd6);
        check("basic busy in done", {31'd0, busy}, 32'd1);
        exp_done++;
        @(posedge clk); #1;
        check("basic busy after", {31'd0, busy}, 32'd0);

        // Backpressure on word 1.
        load(32'd10, 32'd200, 32'd300, 32'd100, 3'b110);
        start_pulse();
        @(posedge clk); #1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp valid held", {31'd0, out_valid}, 32'd1);
            check("bp data held", out_data, 32'd200);
            check("bp last held", {31'd0, out_last}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(edges);
        exp_done++;
        @(posedge clk); #1;

        // Boundary compares.
        sweep(32'd100, 32'd99, 32'd500, 32'd100, 3'b101, "bnd eq");
        sweep(32'd0, 32'd0, 32'd0, 32'd0, 3'b111, "bnd zero");
        sweep(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, "bnd max");

        // Asynchronous reset during SEND of word 1.
        load(32'd1, 32'd2, 32'd3, 32'd2, 3'b110);
        start_pulse();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst pre valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst valid", {31'd0, out_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst spins", {29'd0, spins}, 32'd0);
        check("rst rd_addr", rd_addr, BASE);
        exp_q.delete();
        spins_q.delete();
        @(negedge clk); #1 rst = 1'b0;
        sweep(32'd1000, 32'd2000, 32'd3000, 32'd1500, 3'b110, "post rst");

        // start while busy, and start during DONE.
        load(32'd5, 32'd6, 32'd7, 32'd6, 3'b110);
        start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(edges);
        check("busy-start done latency", 32'(edges), 32'd4);
        exp_done++;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("done-start ignored busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("done-start ignored valid", {31'd0, out_valid}, 32'd0);
        check("done-start ignored busy2", {31'd0, busy}, 32'd0);

        // N=1 instance.
        sweep1(32'd50, 32'd50, 1'b1);
        sweep1(32'd49, 32'd50, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("n3 words left", 32'(exp_q.size()), 32'd0);
        check("n3 spins left", 32'(spins_q.size()), 32'd0);
        check("n1 words left", 32'(exp1_q.size()), 32'd0);
        check("n1 spins left", 32'(spins1_q.size()), 32'd0);
        check("n3 done pulses", 32'(done_cnt), 32'(exp_done));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
